// File: rtl/sdram_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_cache: direct-mapped write-back cache in front of a Gowin SDRAM     |
// | controller, with periodic auto-refresh. Optional: CACHE_ASSERTIONS_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sdram_cache #(
  parameter int LineIndexBitWidth     = 1,
  parameter int RamAddressBitWidth    = 8,
  parameter int ReadDataDelay         = 4,
  parameter int RefreshIntervalCycles = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_enable,
  output logic [31:0] data_out,
  output logic        data_out_ready,
  output logic        busy,
  output logic        I_sdrc_cmd_en,
  output logic [2:0]  I_sdrc_cmd,
  output logic        I_sdrc_precharge_ctrl,
  output logic        I_sdram_power_down,
  output logic        I_sdram_selfrefresh,
  output logic [20:0] I_sdrc_addr,
  output logic [3:0]  I_sdrc_dqm,
  output logic [31:0] I_sdrc_data,
  output logic [7:0]  I_sdrc_data_len,
  input  logic [31:0] O_sdrc_data,
  input  logic        O_sdrc_init_done,
  input  logic        O_sdrc_cmd_ack
);

  localparam int   c_LINES = 2 ** LineIndexBitWidth;
  localparam int   c_TAGW  = RamAddressBitWidth - 3 - LineIndexBitWidth;
  localparam int   c_REFW  = $clog2(RefreshIntervalCycles + 1);
  localparam logic [c_REFW-1:0] c_REF_MAX  = c_REFW'(RefreshIntervalCycles);
  localparam logic [c_REFW-1:0] c_REF_ONE  = c_REFW'(1);
  localparam logic [7:0]        c_RX_FIRST = 8'(ReadDataDelay);
  localparam logic [7:0]        c_RX_LAST  = 8'(ReadDataDelay + 7);
  localparam logic [2:0] c_CMD_NOP     = 3'b111;
  localparam logic [2:0] c_CMD_ACTIVE  = 3'b011;
  localparam logic [2:0] c_CMD_READ    = 3'b101;
  localparam logic [2:0] c_CMD_WRITE   = 3'b100;
  localparam logic [2:0] c_CMD_REFRESH = 3'b001;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_IDLE      = 4'd1,
    S_REFRESH   = 4'd2,
    S_WB_ACT    = 4'd3,
    S_WB_WR     = 4'd4,
    S_WB_GAP    = 4'd5,
    S_FETCH_ACT = 4'd6,
    S_FETCH_RD  = 4'd7,
    S_FETCH_RX  = 4'd8
  } state_t;

  state_t r_state, w_state_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic                    r_acked, w_acked_nxt;
  logic [c_REFW-1:0]       r_ref_cnt;
  logic [c_LINES-1:0]      r_valid, r_dirty;
  logic [c_TAGW-1:0]       r_tag  [c_LINES];
  logic [31:0]             r_data [c_LINES][8];

  logic [2:0]                   w_off;
  logic [LineIndexBitWidth-1:0] w_idx;
  logic [c_TAGW-1:0]            w_tag;
  logic                         w_hit, w_ref_due, w_serve, w_wr_hit;
  logic                         w_fill, w_fill_done;
  logic [2:0]                   w_rx_off;
  logic [20:0]                  w_victim_addr, w_fetch_addr;
  logic                         w_unused;

  assign w_off = address[4:2];
  assign w_idx = address[4+LineIndexBitWidth:5];
  assign w_tag = address[RamAddressBitWidth+1:5+LineIndexBitWidth];
  assign w_unused = &{1'b0, address[31:RamAddressBitWidth+2], address[1:0]};

  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ref_due = (r_ref_cnt >= c_REF_MAX);
  // Refresh due blocks new requests in IDLE so it wins over a pending miss.
  assign w_serve   = (r_state == S_IDLE) && !w_ref_due;
  assign w_wr_hit  = w_serve && enable && (write_enable != 4'b0000) && w_hit;

  assign busy           = !(w_serve && (!enable || w_hit));
  assign data_out_ready = w_serve && enable && (write_enable == 4'b0000) && w_hit;
  assign data_out       = r_data[w_idx][w_off];

  assign w_victim_addr = 21'({r_tag[w_idx], w_idx, 3'b000});
  assign w_fetch_addr  = 21'({w_tag, w_idx, 3'b000});
  assign w_rx_off      = r_cnt[2:0] - c_RX_FIRST[2:0];

  assign I_sdrc_precharge_ctrl = 1'b1;
  assign I_sdram_power_down    = 1'b0;
  assign I_sdram_selfrefresh   = 1'b0;
  assign I_sdrc_dqm            = 4'b0000;
  assign I_sdrc_data_len       = 8'd7;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acked_nxt   = r_acked;
    I_sdrc_cmd_en = 1'b0;
    I_sdrc_cmd    = c_CMD_NOP;
    I_sdrc_addr   = 21'd0;
    I_sdrc_data   = 32'd0;
    w_fill        = 1'b0;
    w_fill_done   = 1'b0;
    case (r_state)
      S_INIT: if (O_sdrc_init_done) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_ref_due)
          w_state_nxt = S_REFRESH;
        else if (enable && !w_hit)
          w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB_ACT : S_FETCH_ACT;
      end
      S_REFRESH: begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = c_CMD_REFRESH;
        if (O_sdrc_cmd_ack) w_state_nxt = S_IDLE;
      end
      S_WB_ACT: begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = c_CMD_ACTIVE;
        I_sdrc_addr   = w_victim_addr;
        if (O_sdrc_cmd_ack) begin
          w_state_nxt = S_WB_WR;
          w_cnt_nxt   = 8'd0;
          w_acked_nxt = 1'b0;
        end
      end
      S_WB_WR: begin
        // Word 0 is presented while waiting for the ack, word k in cycle ack+k.
        I_sdrc_addr = w_victim_addr;
        I_sdrc_data = r_data[w_idx][r_cnt[2:0]];
        if (!r_acked) begin
          I_sdrc_cmd_en = 1'b1;
          I_sdrc_cmd    = c_CMD_WRITE;
          if (O_sdrc_cmd_ack) begin
            w_acked_nxt = 1'b1;
            w_cnt_nxt   = 8'd1;
          end
        end else if (r_cnt == 8'd7) begin
          w_state_nxt = S_WB_GAP;
          w_cnt_nxt   = 8'd0;
          w_acked_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WB_GAP: begin
        if (r_cnt == 8'd3) begin
          w_state_nxt = S_FETCH_ACT;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_FETCH_ACT: begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = c_CMD_ACTIVE;
        I_sdrc_addr   = w_fetch_addr;
        if (O_sdrc_cmd_ack) w_state_nxt = S_FETCH_RD;
      end
      S_FETCH_RD: begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = c_CMD_READ;
        I_sdrc_addr   = w_fetch_addr;
        if (O_sdrc_cmd_ack) begin
          w_state_nxt = S_FETCH_RX;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_FETCH_RX: begin
        // r_cnt counts cycles since the READ ack.
        I_sdrc_addr = w_fetch_addr;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_fill      = (r_cnt >= c_RX_FIRST);
        if (r_cnt == c_RX_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
          w_fill_done = 1'b1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_cnt     <= 8'd0;
      r_acked   <= 1'b0;
      r_ref_cnt <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acked <= w_acked_nxt;
      if (r_state == S_REFRESH && O_sdrc_cmd_ack)
        r_ref_cnt <= '0;
      else if (r_ref_cnt < c_REF_MAX)
        r_ref_cnt <= r_ref_cnt + c_REF_ONE;
      if (w_wr_hit)
        r_dirty[w_idx] <= 1'b1;
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (write_enable[b]) r_data[w_idx][w_off][8*b +: 8] <= data_in[8*b +: 8];
    end
    if (w_fill)
      r_data[w_idx][w_rx_off] <= O_sdrc_data;
    if (w_fill_done)
      r_tag[w_idx] <= w_tag;
  end

`ifdef CACHE_ASSERTIONS_EN
  a_hold_inputs: assert property (@(posedge clk) disable iff (rst)
    (busy && enable) |=> ($stable(address) && $stable(write_enable) && $stable(data_in)));
  a_ack_pending: assert property (@(posedge clk) disable iff (rst)
    O_sdrc_cmd_ack |-> I_sdrc_cmd_en);
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_cache: directed bench for sdram_cache with a small SDRAM model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sdram_cache;

  localparam int RDD = 4;
  localparam int RIC = 200;
  localparam int ACK_DELAY = 1;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] address, data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready, busy;
  logic        I_sdrc_cmd_en, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh;
  logic [2:0]  I_sdrc_cmd;
  logic [20:0] I_sdrc_addr;
  logic [3:0]  I_sdrc_dqm;
  logic [31:0] I_sdrc_data;
  logic [7:0]  I_sdrc_data_len;
  logic [31:0] O_sdrc_data = 32'd0;
  logic        O_sdrc_init_done;
  logic        O_sdrc_cmd_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_cache #(
    .LineIndexBitWidth(1), .RamAddressBitWidth(8),
    .ReadDataDelay(RDD), .RefreshIntervalCycles(RIC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out), .data_out_ready(data_out_ready),
    .busy(busy), .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd),
    .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl), .I_sdram_power_down(I_sdram_power_down),
    .I_sdram_selfrefresh(I_sdram_selfrefresh), .I_sdrc_addr(I_sdrc_addr),
    .I_sdrc_dqm(I_sdrc_dqm), .I_sdrc_data(I_sdrc_data), .I_sdrc_data_len(I_sdrc_data_len),
    .O_sdrc_data(O_sdrc_data), .O_sdrc_init_done(O_sdrc_init_done),
    .O_sdrc_cmd_ack(O_sdrc_cmd_ack)
  );

  always #5 clk = ~clk;

  // SDRAM controller model: acks after ACK_DELAY cycles, mid-cycle driving.
  logic [31:0] mem [256];
  int mcyc = 0, wait_cnt = 0, wr_k = 0, rd_start = 0;
  bit wr_active = 0, rd_active = 0;
  logic [20:0] wr_addr, rd_addr;
  int n_ref = 0, n_act = 0, n_wr = 0, n_rd = 0;

  always @(negedge clk) begin
    mcyc = mcyc + 1;
    O_sdrc_cmd_ack = 1'b0;
    O_sdrc_data = 32'hDEAD_BEEF;
    if (rst) begin
      wr_active = 0; rd_active = 0; wait_cnt = 0;
    end else begin
      if (I_sdrc_cmd_en) begin
        if (wait_cnt == ACK_DELAY) begin
          O_sdrc_cmd_ack = 1'b1;
          wait_cnt = 0;
          case (I_sdrc_cmd)
            3'b001: n_ref++;
            3'b011: n_act++;
            3'b100: begin n_wr++; wr_active = 1; wr_k = 0; wr_addr = I_sdrc_addr; end
            3'b101: begin n_rd++; rd_active = 1; rd_start = mcyc + RDD; rd_addr = I_sdrc_addr; end
            default: ;
          endcase
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (wr_active) begin
        mem[8'(int'(wr_addr) + wr_k)] = I_sdrc_data;
        wr_k++;
        if (wr_k == 8) wr_active = 0;
      end
      if (rd_active && mcyc >= rd_start) begin
        O_sdrc_data = mem[8'(int'(rd_addr) + mcyc - rd_start)];
        if (mcyc - rd_start == 7) rd_active = 0;
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                     output logic [31:0] q, output logic rdy, output int lat);
    bit done;
    @(negedge clk);
    enable = 1'b1; address = a; data_in = d; write_enable = we;
    lat = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      #1;
      if (!busy) done = 1;
      else begin @(negedge clk); lat++; end
    end
    q = data_out; rdy = data_out_ready;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL req_timeout addr=%h: busy still 1, required 0", a);
    end
    @(posedge clk); #1;
    enable = 1'b0; write_enable = 4'b0000;
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1; O_sdrc_init_done = 1'b0; enable = 1'b0;
    address = 32'd0; data_in = 32'd0; write_enable = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({busy, data_out_ready, I_sdrc_cmd_en, I_sdrc_cmd} !== 6'b1_0_0_111) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/rdy/en/cmd=%b required 100111",
               {busy, data_out_ready, I_sdrc_cmd_en, I_sdrc_cmd});
    end
    n_tests++;
    if ({I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh, I_sdrc_dqm, I_sdrc_data_len}
        !== {1'b1, 1'b0, 1'b0, 4'h0, 8'd7}) begin
      n_fail++;
      $display("FAIL reset_static: pre=%b pd=%b sr=%b dqm=%h len=%0d required 1 0 0 0 7",
               I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh, I_sdrc_dqm, I_sdrc_data_len);
    end
    n_tests++;
    if ({I_sdrc_addr, I_sdrc_data} !== 53'd0) begin
      n_fail++;
      $display("FAIL reset_addr_data: addr=%h data=%h required 0 0", I_sdrc_addr, I_sdrc_data);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_init: busy=%b required 1", busy);
    end
    O_sdrc_init_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL busy_after_init: busy=%b required 0", busy);
    end
    n_tests++;
    if (data_out_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_idle: data_out_ready=%b required 0", data_out_ready);
    end
    for (int i = 0; i < RIC + 20 && n_ref == 0; i++) @(negedge clk);
    n_tests++;
    if (n_ref != 1) begin
      n_fail++;
      $display("FAIL first_refresh: refresh count=%0d required 1", n_ref);
    end
  endtask

  task automatic test_cold_write;
    logic [31:0] q; logic rdy; int lat, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    req(32'd4, 32'h1234_5678, 4'b1111, q, rdy, lat);
    n_tests++;
    if (lat == 0 || n_rd != rd0 + 1 || n_wr != wr0) begin
      n_fail++;
      $display("FAIL cold_miss: lat=%0d reads=%0d writes=%0d required lat>0 reads=%0d writes=%0d",
               lat, n_rd - rd0, n_wr - wr0, 1, 0);
    end
  endtask

  task automatic test_hit_read;
    logic [31:0] q; logic rdy; int lat, ref0;
    logic [31:0] exp_q [3];
    logic [31:0] addrs [3];
    addrs = '{32'd4, 32'd0, 32'd28};
    exp_q = '{32'h1234_5678, 32'hA500_0000, 32'hA500_0007};
    for (int k = 0; k < 3; k++) begin
      ref0 = n_ref;
      req(addrs[k], 32'd0, 4'b0000, q, rdy, lat);
      n_tests++;
      if (q !== exp_q[k] || rdy !== 1'b1 || (lat != 0 && n_ref == ref0)) begin
        n_fail++;
        $display("FAIL hit_read[%0d]: data=%h rdy=%b lat=%0d required %h 1 0", k, q, rdy, lat, exp_q[k]);
      end
    end
  endtask

  task automatic test_dirty_evict;
    logic [31:0] q; logic rdy; int lat, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    req(32'd70, 32'hABCD_EF01, 4'b1111, q, rdy, lat);
    n_tests++;
    if (n_wr != wr0 + 1 || n_rd != rd0 + 1) begin
      n_fail++;
      $display("FAIL evict_cmds: writes=%0d reads=%0d required 1 1", n_wr - wr0, n_rd - rd0);
    end
    n_tests++;
    if (mem[0] !== 32'hA500_0000 || mem[1] !== 32'h1234_5678 || mem[7] !== 32'hA500_0007) begin
      n_fail++;
      $display("FAIL writeback_data: mem0=%h mem1=%h mem7=%h required a5000000 12345678 a5000007",
               mem[0], mem[1], mem[7]);
    end
    req(32'd68, 32'd0, 4'b0000, q, rdy, lat);
    n_tests++;
    if (q !== 32'hABCD_EF01 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_new_line: data=%h rdy=%b required abcdef01 1", q, rdy);
    end
    req(32'd72, 32'd0, 4'b0000, q, rdy, lat);
    n_tests++;
    if (q !== 32'hA500_0012 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_fetched_word: data=%h rdy=%b required a5000012 1", q, rdy);
    end
  endtask

  task automatic test_refetch;
    logic [31:0] q; logic rdy; int lat, wr0;
    wr0 = n_wr;
    req(32'd4, 32'd0, 4'b0000, q, rdy, lat);
    n_tests++;
    if (q !== 32'h1234_5678 || rdy !== 1'b1 || lat == 0) begin
      n_fail++;
      $display("FAIL refetch_read: data=%h rdy=%b lat=%0d required 12345678 1 >0", q, rdy, lat);
    end
    n_tests++;
    if (mem[17] !== 32'hABCD_EF01 || n_wr != wr0 + 1) begin
      n_fail++;
      $display("FAIL evict_line70: mem17=%h writes=%0d required abcdef01 1", mem[17], n_wr - wr0);
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] q; logic rdy; int lat;
    req(32'd4, 32'h0000_AA00, 4'b0010, q, rdy, lat);
    n_tests++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ready: data_out_ready=%b required 0", rdy);
    end
    req(32'd4, 32'd0, 4'b0000, q, rdy, lat);
    n_tests++;
    if (q !== 32'h1234_AA78 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL byte_enable: data=%h rdy=%b required 1234aa78 1", q, rdy);
    end
  endtask

  task automatic test_reset_mid_fetch;
    logic [31:0] q; logic rdy; int lat, rd0;
    rd0 = n_rd;
    @(negedge clk);
    enable = 1'b1; address = 32'd200; data_in = 32'd0; write_enable = 4'b0000;
    for (int i = 0; i < 300 && n_rd == rd0; i++) @(negedge clk);
    n_tests++;
    if (n_rd != rd0 + 1) begin
      n_fail++;
      $display("FAIL fetch_start: reads=%0d required 1", n_rd - rd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (busy !== 1'b1 || I_sdrc_cmd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fetch: busy=%b cmd_en=%b required 1 0", busy, I_sdrc_cmd_en);
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (mem[1] !== 32'h1234_AA78) begin
      n_fail++;
      $display("FAIL dirty_wb_before_fetch: mem1=%h required 1234aa78", mem[1]);
    end
    rd0 = n_rd;
    req(32'd4, 32'd0, 4'b0000, q, rdy, lat);
    n_tests++;
    if (q !== 32'h1234_AA78 || rdy !== 1'b1 || lat == 0 || n_rd != rd0 + 1) begin
      n_fail++;
      $display("FAIL read_after_reset: data=%h rdy=%b lat=%0d reads=%0d required 1234aa78 1 >0 1",
               q, rdy, lat, n_rd - rd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    test_reset();
    test_cold_write();
    test_hit_read();
    test_dirty_evict();
    test_refetch();
    test_byte_enable();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
